controlador_de_interrupcao: RTL and testbench

CONTROLADOR_DE_INTERRUPCAO -- requirements
Module: controlador_de_interrupcao

---
 rtl/controlador_de_interrupcao.sv | 91 +++++++++
 tb/tb_controlador_de_interrupcao.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller: edge-detects 8 request lines into a pending register, masks them and
// hands the lowest enabled request to the CPU at an instruction boundary (no nesting).
module controlador_de_interrupcao (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic       boundary,
    input  logic       reti,
    input  logic       wr_mask,
    input  logic [7:0] mask_in,
    output logic       inta,
    output logic [2:0] irq_id,
    output logic       in_service,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {StIdle, StAck, StService} state_e;

    state_e     state_q, state_d;
    logic [7:0] irq_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q;
    logic [7:0] enabled;
    logic [7:0] grant_clr;
    logic [2:0] irq_id_q, irq_id_d;
    logic [2:0] lowest;

    assign enabled = pending_q & mask_q;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (enabled[i]) begin
                lowest = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        grant_clr = 8'h00;
        case (state_q)
            StIdle: begin
                if (boundary && (enabled != 8'h00)) begin
                    state_d   = StAck;
                    irq_id_d  = lowest;
                    grant_clr = 8'd1 << lowest;
                end
            end
            StAck: begin
                state_d = StService;
            end
            StService: begin
                if (reti) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A fresh edge on the line being acknowledged keeps its bit set.
        pending_d = (pending_q & ~grant_clr) | (irq & ~irq_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            irq_q     <= 8'h00;
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
            irq_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            irq_id_q  <= irq_id_d;
            if (wr_mask) begin
                mask_q <= mask_in;
            end
        end
    end

    assign inta       = (state_q == StAck);
    assign in_service = (state_q == StAck) || (state_q == StService);
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Self-checking bench for controlador_de_interrupcao: directed scenarios plus randomized traffic
// compared against a behavioural model of the controller.
module tb_controlador_de_interrupcao;

    logic       clk;
    logic       reset;
    logic [7:0] irq;
    logic       boundary;
    logic       reti;
    logic       wr_mask;
    logic [7:0] mask_in;
    logic       inta;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a handler is either idle, in its acknowledge cycle, or running.
    logic [7:0] m_pend, m_mask, m_prev;
    logic [2:0] m_id;
    bit         m_active;
    bit         m_ackcyc;

    controlador_de_interrupcao dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .boundary   (boundary),
        .reti       (reti),
        .wr_mask    (wr_mask),
        .mask_in    (mask_in),
        .inta       (inta),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Advance the model with the inputs the DUT is about to sample.
    task automatic model_step();
        logic [7:0] rising;
        logic [7:0] cleared;
        logic [7:0] candidates;
        rising  = irq & ~m_prev;
        cleared = 8'h00;
        if (!reset) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_id = 3'd0; m_active = 0; m_ackcyc = 0;
            return;
        end
        candidates = m_pend & m_mask;
        if (m_ackcyc) begin
            m_ackcyc = 0;
        end else if (m_active) begin
            if (reti) m_active = 0;
        end else if (boundary && candidates != 0) begin
            for (int k = 0; k < 8; k++) begin
                if (candidates[k]) begin
                    m_id    = 3'(k);
                    cleared = 8'h00;
                    cleared[k] = 1'b1;
                    break;
                end
            end
            m_active = 1;
            m_ackcyc = 1;
        end
        m_pend = (m_pend & ~cleared) | rising;
        if (wr_mask) m_mask = mask_in;
        m_prev = irq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; irq = 8'h00; boundary = 1'b0; reti = 1'b0;
        wr_mask = 1'b0; mask_in = 8'h00;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_mask(input logic [7:0] m);
        wr_mask = 1'b1; mask_in = m;
        tick();
        wr_mask = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq = 8'hFF; boundary = 1'b1; reti = 1'b1;
        wr_mask = 1'b1; mask_in = 8'hFF;
        tick();
        checks++;
        if (pending !== 8'h00 || inta !== 1'b0 || in_service !== 1'b0 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: pending=%h inta=%b in_service=%b irq_id=%0d, want 00 0 0 0",
                     pending, inta, in_service, irq_id);
        end
        // Line still high at release is seen as an edge; mask was not loaded under reset.
        reset = 1'b1; wr_mask = 1'b0; reti = 1'b0;
        tick();
        checks++;
        if (pending !== 8'hFF) begin
            errors++;
            $display("FAIL reset_release_edge: pending=%h want ff", pending);
        end
        repeat (3) tick();
        checks++;
        if (inta !== 1'b0 || pending !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mask_cleared: inta=%b pending=%h want 0 ff", inta, pending);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_mask(8'hFF);
        boundary = 1'b1; irq = 8'h08;
        tick();
        checks++;
        if (pending !== 8'h08 || inta !== 1'b0) begin
            errors++;
            $display("FAIL single_pending: pending=%h inta=%b want 08 0", pending, inta);
        end
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd3 || pending !== 8'h00 || in_service !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: inta=%b irq_id=%0d pending=%h in_service=%b want 1 3 00 1",
                     inta, irq_id, pending, in_service);
        end
        irq = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inta !== 1'b0 || in_service !== 1'b1 || irq_id !== 3'd3) begin
                errors++;
                $display("FAIL single_service: inta=%b in_service=%b irq_id=%0d want 0 1 3",
                         inta, in_service, irq_id);
            end
        end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checks++;
        if (in_service !== 1'b0 || inta !== 1'b0 || irq_id !== 3'd3) begin
            errors++;
            $display("FAIL single_reti: in_service=%b inta=%b irq_id=%0d want 0 0 3",
                     in_service, inta, irq_id);
        end
    endtask

    task automatic test_two_lines();
        do_reset();
        set_mask(8'hFF);
        boundary = 1'b1; irq = 8'h24;
        tick();
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd2 || pending !== 8'h20) begin
            errors++;
            $display("FAIL two_first: inta=%b irq_id=%0d pending=%h want 1 2 20",
                     inta, irq_id, pending);
        end
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checks++;
        if (inta !== 1'b0 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL two_idle_after_reti: inta=%b in_service=%b want 0 0", inta, in_service);
        end
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd5 || pending !== 8'h00) begin
            errors++;
            $display("FAIL two_second: inta=%b irq_id=%0d pending=%h want 1 5 00",
                     inta, irq_id, pending);
        end
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic test_masked();
        do_reset();
        boundary = 1'b1; irq = 8'h02;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pending !== 8'h02 || inta !== 1'b0) begin
                errors++;
                $display("FAIL masked_hold: pending=%h inta=%b want 02 0", pending, inta);
            end
        end
        set_mask(8'h02);
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd1 || pending !== 8'h00) begin
            errors++;
            $display("FAIL masked_unmask: inta=%b irq_id=%0d pending=%h want 1 1 00",
                     inta, irq_id, pending);
        end
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic test_boundary();
        do_reset();
        set_mask(8'hFF);
        boundary = 1'b0; irq = 8'h10;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (inta !== 1'b0 || pending !== 8'h10) begin
                errors++;
                $display("FAIL boundary_wait: inta=%b pending=%h want 0 10", inta, pending);
            end
        end
        boundary = 1'b1;
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd4) begin
            errors++;
            $display("FAIL boundary_ack: inta=%b irq_id=%0d want 1 4", inta, irq_id);
        end
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic test_edge_in_service();
        do_reset();
        set_mask(8'hFF);
        boundary = 1'b1; irq = 8'h80;
        tick();
        tick();
        tick();
        irq = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inta !== 1'b0 || pending !== 8'h01 || irq_id !== 3'd7) begin
                errors++;
                $display("FAIL nest_blocked: inta=%b pending=%h irq_id=%0d want 0 01 7",
                         inta, pending, irq_id);
            end
        end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checks++;
        if (inta !== 1'b0) begin
            errors++;
            $display("FAIL nest_reti_gap: inta=%b want 0", inta);
        end
        tick();
        checks++;
        if (inta !== 1'b1 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL nest_after_reti: inta=%b irq_id=%0d want 1 0", inta, irq_id);
        end
    endtask

    task automatic test_reset_in_service();
        // Continues from the SERVICE state left by the previous scenario.
        tick();
        reset = 1'b0; wr_mask = 1'b1; mask_in = 8'hFF; irq = 8'h0F; reti = 1'b1;
        tick();
        checks++;
        if (in_service !== 1'b0 || inta !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: in_service=%b inta=%b pending=%h want 0 0 00",
                     in_service, inta, pending);
        end
        reset = 1'b1; wr_mask = 1'b0; reti = 1'b0; boundary = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inta !== 1'b0 || in_service !== 1'b0 || pending !== 8'h0F) begin
                errors++;
                $display("FAIL reset_abort_quiet: inta=%b in_service=%b pending=%h want 0 0 0f",
                         inta, in_service, pending);
            end
        end
    endtask

    task automatic test_random();
        logic prev_inta;
        do_reset();
        prev_inta = 1'b0;
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) != 0);
            irq      = irq ^ (8'($urandom) & 8'($urandom));
            boundary = ($urandom_range(0, 3) != 0);
            reti     = ($urandom_range(0, 4) == 0);
            wr_mask  = ($urandom_range(0, 7) == 0);
            mask_in  = 8'($urandom);
            tick();
            checks++;
            if (inta !== m_ackcyc || in_service !== m_active || irq_id !== m_id ||
                pending !== m_pend) begin
                errors++;
                $display("FAIL random_cycle%0d: inta=%b in_service=%b irq_id=%0d pending=%h want %b %b %0d %h",
                         n, inta, in_service, irq_id, pending, m_ackcyc, m_active, m_id, m_pend);
            end
            checks++;
            if (prev_inta === 1'b1 && inta === 1'b1) begin
                errors++;
                $display("FAIL random_inta_width%0d: inta=1 twice in a row, want single pulse", n);
            end
            prev_inta = inta;
        end
    endtask

    initial begin
        reset = 1'b0; irq = 8'h00; boundary = 1'b0; reti = 1'b0;
        wr_mask = 1'b0; mask_in = 8'h00;
        m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00; m_id = 3'd0;
        m_active = 0; m_ackcyc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_two_lines();
        test_masked();
        test_boundary();
        test_edge_in_service();
        test_reset_in_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
